// File: rtl/rv32_pkg.sv
// Shared RV32 fetch-side definitions: word width, the NOP encoding and the fetch FSM states.
package rv32_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            fault;
    } fetch_entry_t;
endpackage

// File: rtl/ifetch_fifo.sv
// Generic synchronous FIFO with clear and first-word-fall-through head output.
// Zero-latency read from the head; a push into a full FIFO is only taken alongside a pop.
module ifetch_fifo #(
    parameter int W     = 65,
    parameter int DEPTH = 2,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear_i,
    input  logic          push_i,
    input  logic [W-1:0]  push_dat_i,
    input  logic          pop_i,
    output logic [W-1:0]  head_dat_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == CW'(DEPTH));
    assign count_o    = count_q;
    assign head_dat_o = mem_q[rd_ptr_q];

    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
            else if (!push_ok && pop_ok) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing is visible until count_q says so.
    always_ff @(posedge clk) begin
        if (push_ok && !clear_i) mem_q[wr_ptr_q] <= push_dat_i;
    end
endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: one outstanding imem read per PC, results queued for decode.
// 3 cycles PC-to-PC with zero-wait memory; stops issuing while the queue has no room.
module ifetch_unit import rv32_pkg::*; #(
    parameter int          DEPTH       = 2,
    parameter logic [31:0] RESET_INSTR = NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    input  logic        flush,
    output logic        pc_advance,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_fault,
    input  logic        instr_ready
);
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e  state_q;
    logic [31:0]   addr_q;
    logic          drop_q;

    fetch_entry_t  push_dat, head_dat;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          pop, room, aligned, mis_push, mem_push, push;

    assign pop     = ~fifo_empty & instr_ready;
    assign room    = (fifo_count < CW'(DEPTH)) | pop;
    assign aligned = (pc_in[1:0] == 2'b00);

    assign mis_push = (state_q == IDLE) & room & ~flush & ~aligned;
    assign mem_push = (state_q == WAIT) & imem_rvalid & ~drop_q & ~flush;
    assign push     = mis_push | mem_push;

    always_comb begin
        push_dat = '{pc: addr_q, instr: imem_rdata, fault: 1'b0};
        if (mis_push) push_dat = '{pc: pc_in, instr: 32'h0, fault: 1'b1};
    end

    assign pc_advance = push;
    assign imem_req   = (state_q == REQ);
    assign imem_addr  = addr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            drop_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (room && !flush && aligned) begin
                        addr_q  <= {pc_in[31:2], 2'b00};
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (flush)    drop_q  <= 1'b1;
                    if (imem_gnt) state_q <= WAIT;
                end
                WAIT: begin
                    // A redirect landing on the rvalid cycle is covered by ~flush in mem_push.
                    if (imem_rvalid) begin
                        drop_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (flush) begin
                        drop_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) assert (!(push && fifo_full && !pop));
    end

    ifetch_fifo #(
        .W     ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (flush),
        .push_i     (push),
        .push_dat_i (push_dat),
        .pop_i      (pop),
        .head_dat_o (head_dat),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count)
    );

    assign instr_valid = ~fifo_empty;
    assign instr       = fifo_empty ? RESET_INSTR : head_dat.instr;
    assign instr_pc    = fifo_empty ? 32'h0 : head_dat.pc;
    assign instr_fault = fifo_empty ? 1'b0 : head_dat.fault;
endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: vector table of single fetches plus backpressure, flush and reset sequences.
module tb_ifetch_unit;
    logic        clk, reset, flush, instr_ready;
    logic [31:0] pc_in;
    logic        pc_advance, imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        instr_valid, instr_fault;
    logic [31:0] instr, instr_pc;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int gnt_dly = 0;
    int rv_dly  = 0;
    logic        chk_en   = 1'b0;
    logic [31:0] chk_addr = 32'h0;

    ifetch_unit #(.DEPTH(2), .RESET_INSTR(32'h0000_0013)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_in       (pc_in),
        .flush       (flush),
        .pc_advance  (pc_advance),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_fault (instr_fault),
        .instr_ready (instr_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Memory: grant after gnt_dly request cycles, data rv_dly+1 cycles after grant; word = {DEAD, addr[15:0]}.
    initial begin
        int wcnt, rv_cnt;
        logic [31:0] rv_addr;
        wcnt = 0; rv_cnt = 0; rv_addr = 32'h0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            imem_rvalid = (rv_cnt == 1);
            imem_rdata  = imem_rvalid ? {16'hDEAD, rv_addr[15:0]} : 32'h0;
            if (rv_cnt > 0) rv_cnt--;
            imem_gnt = 1'b0;
            if (imem_req) begin
                if (wcnt >= gnt_dly) begin
                    imem_gnt = 1'b1;
                    rv_cnt   = rv_dly + 1;
                    rv_addr  = imem_addr;
                    wcnt     = 0;
                end else begin
                    wcnt++;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Waits for pc_advance, counting rising edges crossed; checks imem_addr while a request is pending.
    task automatic wait_adv(input string nm, output int n);
        bit got;
        got = 1'b0;
        n = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk); #1;
            if (chk_en && imem_req) chk({nm, "_addr_hold"}, imem_addr, chk_addr);
            if (pc_advance) got = 1'b1;
            else begin
                @(posedge clk);
                n++;
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no pc_advance want pc_advance within 40 cycles", nm);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wait_sig_gnt(input string nm);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk); #1;
            if (imem_gnt) got = 1'b1;
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL %s_gnt_timeout: got no grant want grant within 40 cycles", nm);
        end
    endtask

    task automatic wait_sig_rv(input string nm);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk); #1;
            if (imem_rvalid) got = 1'b1;
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL %s_rv_timeout: got no rvalid want rvalid within 40 cycles", nm);
        end
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_req"},   imem_req,    1'b0);
        chk({nm, "_addr"},  imem_addr,   32'h0);
        chk({nm, "_adv"},   pc_advance,  1'b0);
        chk({nm, "_vld"},   instr_valid, 1'b0);
        chk({nm, "_instr"}, instr,       32'h0000_0013);
        chk({nm, "_ipc"},   instr_pc,    32'h0);
        chk({nm, "_fault"}, instr_fault, 1'b0);
    endtask

    typedef struct {
        logic [31:0] pc;
        int          gd;
        int          cyc;
        int          gap;
        logic        fault;
        logic [31:0] ins;
    } vec_t;

    initial begin
        vec_t vt[8];
        int   n, last_adv;

        vt[0] = '{32'h0000_0000, 0, 2, 0, 1'b0, 32'hDEAD_0000};
        vt[1] = '{32'h0000_0004, 0, 2, 3, 1'b0, 32'hDEAD_0004};
        vt[2] = '{32'h0000_0008, 0, 2, 3, 1'b0, 32'hDEAD_0008};
        vt[3] = '{32'h0000_0100, 4, 6, 0, 1'b0, 32'hDEAD_0100};
        vt[4] = '{32'h0000_0006, 0, 0, 0, 1'b1, 32'h0000_0000};
        vt[5] = '{32'h0000_000C, 0, 2, 0, 1'b0, 32'hDEAD_000C};
        vt[6] = '{32'h0000_0002, 0, 0, 0, 1'b1, 32'h0000_0000};
        vt[7] = '{32'h0000_FFFC, 1, 3, 0, 1'b0, 32'hDEAD_FFFC};

        reset = 1'b1; flush = 1'b0; instr_ready = 1'b1; pc_in = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk_reset_vals("rst");
        step();
        reset = 1'b0;

        last_adv = 0;
        chk_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            pc_in    = vt[i].pc;
            gnt_dly  = vt[i].gd;
            chk_addr = vt[i].pc;
            wait_adv($sformatf("v%0d", i), n);
            chk($sformatf("v%0d_cycles", i), n, vt[i].cyc);
            if (vt[i].gap != 0) chk($sformatf("v%0d_gap", i), cyc - last_adv, vt[i].gap);
            last_adv = cyc;
            if (vt[i].fault) chk($sformatf("v%0d_noreq", i), imem_req, 1'b0);
            step();
            if (!vt[i].fault) chk($sformatf("v%0d_adv_pulse", i), pc_advance, 1'b0);
            chk($sformatf("v%0d_vld", i),   instr_valid, 1'b1);
            chk($sformatf("v%0d_ipc", i),   instr_pc,    vt[i].pc);
            chk($sformatf("v%0d_instr", i), instr,       vt[i].ins);
            chk($sformatf("v%0d_fault", i), instr_fault, vt[i].fault);
        end
        chk_en  = 1'b0;
        gnt_dly = 0;

        // Backpressure: two words fill the queue, then nothing issues until decode drains.
        pc_in = 32'h200;
        step();
        instr_ready = 1'b0;
        wait_adv("bp0", n);
        step();
        pc_in = 32'h204;
        wait_adv("bp1", n);
        step();
        pc_in = 32'h208;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            chk($sformatf("bp_stall_req%0d", k), imem_req,   1'b0);
            chk($sformatf("bp_stall_adv%0d", k), pc_advance, 1'b0);
        end
        chk("bp_head_pc",    instr_pc, 32'h200);
        chk("bp_head_instr", instr,    32'hDEAD_0200);
        instr_ready = 1'b1;
        @(negedge clk); #1;
        chk("bp_resume_req",  imem_req,  1'b1);
        chk("bp_resume_addr", imem_addr, 32'h208);
        wait_adv("bp2", n);
        step();

        // Flush while waiting for data: the late word is dropped, the redirect target fetches normally.
        rv_dly = 3;
        pc_in  = 32'h20;
        wait_sig_gnt("fl");
        @(negedge clk); #1;
        flush = 1'b1;
        pc_in = 32'h80;
        @(negedge clk); #1;
        flush = 1'b0;
        wait_sig_rv("fl");
        chk("fl_drop_adv", pc_advance, 1'b0);
        @(negedge clk); #1;
        chk("fl_drop_vld", instr_valid, 1'b0);
        wait_adv("fl_next", n);
        step();
        chk("fl_next_vld",   instr_valid, 1'b1);
        chk("fl_next_pc",    instr_pc,    32'h80);
        chk("fl_next_instr", instr,       32'hDEAD_0080);

        // Reset in the middle of a read: the old word returns later and must be ignored.
        rv_dly = 4;
        pc_in  = 32'h40;
        wait_sig_gnt("rw");
        @(negedge clk); #1;
        reset   = 1'b1;
        pc_in   = 32'h0;
        gnt_dly = 6;
        @(negedge clk); #1;
        chk_reset_vals("rw");
        reset = 1'b0;
        wait_sig_rv("rw_stale");
        chk("rw_stale_adv", pc_advance, 1'b0);
        @(negedge clk); #1;
        chk("rw_stale_vld", instr_valid, 1'b0);
        wait_adv("rw_next", n);
        step();
        chk("rw_next_vld",   instr_valid, 1'b1);
        chk("rw_next_pc",    instr_pc,    32'h0);
        chk("rw_next_instr", instr,       32'hDEAD_0000);
        chk("rw_next_fault", instr_fault, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction-fetch stage directly downstream of the PC register.
- Takes the registered PC value, issues word reads to instruction memory over a req/gnt/rvalid handshake that tolerates wait states, and buffers returned words in a small FIFO for decode.
- Tells the next-PC logic when to advance the PC (pc_advance). When pc_advance=0, next-PC logic must feed the current PC back into the PC register.

Parameters:
- DEPTH, 2, FIFO entries of {pc, instr, fault}; power of two, ≥2.
- RESET_INSTR, 32'h0000_0013, value driven on instr when the FIFO is empty (NOP).

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high reset
- pc_in  input  32  current PC from PC register
- flush  input  1  redirect (branch/jump taken); discards buffered and in-flight fetches
- pc_advance  output  1  1-cycle pulse: fetch for pc_in is complete; next-PC logic may load the next PC
- imem_req  output  1  memory read request
- imem_addr  output  32  word address ({pc[31:2],2'b00})
- imem_gnt  input  1  request accepted this cycle
- imem_rvalid  input  1  read data valid
- imem_rdata  input  32  read data
- instr_valid  output  1  FIFO head valid
- instr  output  32  FIFO head instruction
- instr_pc  output  32  FIFO head PC
- instr_fault  output  1  head entry is a misaligned-fetch fault
- instr_ready  input  1  decode consumes head when instr_valid and instr_ready

Behaviour:
- Reset values: imem_req=0, imem_addr=0, pc_advance=0, instr_valid=0, instr=RESET_INSTR, instr_pc=0, instr_fault=0. FIFO is emptied, state=IDLE, drop=0.
- Reset overrides everything, including mid-transaction. Any rvalid arriving after reset is ignored.
- Credit rule: count plus outstanding requests must be ≤ DEPTH. At most one request is outstanding.
- FSM states: IDLE, REQ, WAIT.
  - IDLE: if there is room, no flush this cycle, and pc_in[1:0]==0: latch addr=pc_in and go to REQ.
  - IDLE, misaligned case (pc_in[1:0]!=0) with room: push {pc_in, 32'h0, fault=1} and pulse pc_advance. No memory access.
  - REQ: imem_req=1, imem_addr held stable until imem_gnt. On gnt go to WAIT. imem_req must never drop before gnt.
  - WAIT: on imem_rvalid, push {addr, imem_rdata, 0} unless drop=1. Pulse pc_advance the same cycle (only when not dropped), then go to IDLE.
  - Earliest re-issue is the cycle after rvalid. Minimum PC-to-PC throughput is 3 cycles per instruction with zero-wait memory.
- pc_advance is registered-free combinational from the push condition. It is asserted for exactly one cycle per accepted PC.
- Flush:
  - FIFO count is cleared next cycle.
  - In IDLE: no request is issued that cycle.
  - In REQ or WAIT: set drop=1. The transaction completes normally and its data is discarded with no pc_advance. drop clears on that rvalid.
  - Flush coincident with rvalid: data is discarded.
- Simultaneous push and pop: both occur and count is unchanged. A push when full cannot happen under the credit rule; guard it with an assertion.
- FIFO outputs are direct from the head entry (zero-latency read). instr=RESET_INSTR when empty.
- Pointers wrap modulo DEPTH. Count width is $clog2(DEPTH)+1.

Decomposition:
- Shared package rv32_pkg holds: NOP_INSTR (32'h0000_0013), XLEN=32, and the fetch FSM state enum (IDLE/REQ/WAIT).
- One sub-module, ifetch_fifo: generic synchronous FIFO with push/pop/clear, full/empty/count, and first-word-fall-through output.

Test Plan:
- Zero-wait memory (gnt same cycle as req, rvalid next cycle), pc_in=0x0,4,8, instr_ready=1 → three entries with instr_pc 0x0/0x4/0x8 and the matching rdata; pc_advance pulses exactly 3 times, 3 cycles apart.
- gnt delayed 4 cycles → imem_req and imem_addr=0x100 are held stable for all 4 cycles; exactly one push.
- instr_ready=0 with DEPTH=2 → after 2 pushes, imem_req stays 0 and pc_advance stays 0. Raising instr_ready resumes fetching within 1 cycle.
- flush asserted in WAIT for addr 0x20 → the subsequent rvalid pushes nothing, there is no pc_advance, and instr_valid=0. The next fetch of pc_in=0x80 completes normally.
- pc_in=0x6 → no imem_req; entry pushed with instr_fault=1, instr_pc=0x6, and pc_advance pulses.
- reset asserted in WAIT, then released → all outputs at reset values. A stale rvalid after release is ignored, and fetching restarts from pc_in=0.
